// File: rtl/display_driver.sv
// display_driver: samples the output register, converts it to BCD by shift-and-add-3, and scans 4 seven-segment digits.
// Define DISP_BLANK_EN for leading-zero blanking of the hundreds and tens digits.
module display_driver #(
  parameter int SCAN_DIV = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_i,
  input  logic        signed_i,
  output logic        busy_o,
  output logic [11:0] bcd_o,
  output logic        neg_o,
  output logic [7:0]  seg_o,
  output logic [3:0]  dig_o
);
  localparam int PW = $clog2(SCAN_DIV);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state;
  logic [8:0] shadow;
  logic [7:0] sh, mag, seg_n;
  logic [11:0] scr, adj, bcd_n;
  logic [2:0] cnt;
  logic neg_p, neg_n, wrap, blank_h, blank_t;
  logic [PW-1:0] presc;
  logic [3:0] dig_n, nib;
  function automatic logic [7:0] enc(input logic [3:0] v);
    case (v)
      4'd0: return 8'h3F;
      4'd1: return 8'h06;
      4'd2: return 8'h5B;
      4'd3: return 8'h4F;
      4'd4: return 8'h66;
      4'd5: return 8'h6D;
      4'd6: return 8'h7D;
      4'd7: return 8'h07;
      4'd8: return 8'h7F;
      4'd9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction
  // seg_o is computed from next-cycle digit and result so a wrap and a DONE on one edge agree
  always_comb begin
    mag = signed_i && data_i[7] ? 8'(-data_i) : data_i;
    adj = {scr[11:8] >= 4'd5 ? scr[11:8] + 4'd3 : scr[11:8],
           scr[7:4] >= 4'd5 ? scr[7:4] + 4'd3 : scr[7:4],
           scr[3:0] >= 4'd5 ? scr[3:0] + 4'd3 : scr[3:0]};
    wrap = presc == PW'(SCAN_DIV - 1);
    bcd_n = state == DONE ? scr : bcd_o;
    neg_n = state == DONE ? neg_p : neg_o;
    dig_n = dig_o == 4'b0000 ? 4'b0001 : wrap ? {dig_o[2:0], dig_o[3]} : dig_o;
`ifdef DISP_BLANK_EN
    blank_h = bcd_n[11:8] == 4'd0;
    blank_t = blank_h && bcd_n[7:4] == 4'd0;
`else
    blank_h = 1'b0;
    blank_t = 1'b0;
`endif
    nib = dig_n[0] ? bcd_n[3:0] : dig_n[1] ? bcd_n[7:4] : bcd_n[11:8];
    seg_n = dig_n[3] ? (neg_n ? 8'h40 : 8'h00) :
            (dig_n[2] && blank_h) || (dig_n[1] && blank_t) ? 8'h00 : enc(nib);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      shadow <= '0;
      sh <= '0;
      scr <= '0;
      cnt <= '0;
      neg_p <= 1'b0;
      presc <= '0;
      busy_o <= 1'b0;
      bcd_o <= '0;
      neg_o <= 1'b0;
      seg_o <= '0;
      dig_o <= '0;
    end else begin
      presc <= dig_o == 4'b0000 || wrap ? '0 : presc + 1'b1;
      dig_o <= dig_n;
      seg_o <= seg_n;
      bcd_o <= bcd_n;
      neg_o <= neg_n;
      case (state)
        IDLE: if ({signed_i, data_i} != shadow) begin
          shadow <= {signed_i, data_i};
          neg_p <= signed_i && data_i[7];
          sh <= mag;
          scr <= '0;
          cnt <= '0;
          busy_o <= 1'b1;
          state <= CONV;
        end
        CONV: begin
          {scr, sh} <= {adj[10:0], sh, 1'b0};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= DONE;
        end
        DONE: begin
          busy_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_display_driver.sv
// tb_display_driver: vector table plus scoreboard queue of expected results, and scan/reset sequences.
module tb_display_driver;
  logic clk = 0, rst_n = 0, signed_i = 0, busy_o, neg_o;
  logic [7:0] data_i = 0, seg_o;
  logic [11:0] bcd_o, last_bcd;
  logic [3:0] dig_o;
  int errs = 0, checks = 0;
  typedef struct packed {logic s; logic [7:0] d; logic [11:0] bcd; logic neg;} vec_t;
  typedef struct packed {logic [11:0] bcd; logic neg;} exp_t;
  vec_t vecs[7];
  exp_t q[$];
`ifdef DISP_BLANK_EN
  localparam logic [7:0] ZB = 8'h00;
`else
  localparam logic [7:0] ZB = 8'h3F;
`endif
  display_driver #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .signed_i(signed_i),
    .busy_o(busy_o), .bcd_o(bcd_o), .neg_o(neg_o), .seg_o(seg_o), .dig_o(dig_o)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_to_done(input string name, input int n0);
    int n;
    logic partial;
    exp_t e;
    n = n0;
    partial = 0;
    while (busy_o === 1'b1 && n < 30) begin
      if (bcd_o !== last_bcd) partial = 1;
      tick();
      n++;
    end
    chk({name, "_latency"}, n, 10);
    chk({name, "_no_partial"}, partial, 0);
    e = q.pop_front();
    chk({name, "_bcd"}, bcd_o, e.bcd);
    chk({name, "_neg"}, neg_o, e.neg);
    last_bcd = e.bcd;
  endtask
  task automatic convert(input logic s, input logic [7:0] d, input logic [11:0] eb, input logic en, input string name);
    signed_i = s;
    data_i = d;
    q.push_back({eb, en});
    tick();
    chk({name, "_busy_rise"}, busy_o, 1);
    run_to_done(name, 1);
  endtask
  task automatic check_scan(input string name, input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3);
    logic [3:0] prev;
    logic [7:0] exp[4];
    int n;
    exp = '{s0, s1, s2, s3};
    prev = dig_o;
    n = 0;
    while (!(prev == 4'b1000 && dig_o == 4'b0001) && n < 40) begin
      prev = dig_o;
      tick();
      n++;
    end
    chk({name, "_sync"}, n < 40, 1);
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++) begin
        chk({name, "_dig"}, dig_o, 32'(1 << k));
        chk({name, "_seg"}, seg_o, exp[k]);
        tick();
      end
    chk({name, "_dig_wrap"}, dig_o, 4'b0001);
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_bcd", bcd_o, 0);
    chk("rst_neg", neg_o, 0);
    chk("rst_seg", seg_o, 0);
    chk("rst_dig", dig_o, 0);
    rst_n = 1;
    tick();
    chk("rel_dig", dig_o, 4'b0001);
    chk("rel_seg", seg_o, 8'h3F);
    repeat (6) tick();
    chk("idle_no_conv", busy_o, 0);
    last_bcd = 12'h000;
    vecs[0] = {1'b0, 8'hFF, 12'h255, 1'b0};
    vecs[1] = {1'b1, 8'hFF, 12'h001, 1'b1};
    vecs[2] = {1'b1, 8'h80, 12'h128, 1'b1};
    vecs[3] = {1'b1, 8'h7F, 12'h127, 1'b0};
    vecs[4] = {1'b1, 8'h9C, 12'h100, 1'b1};
    vecs[5] = {1'b0, 8'h0A, 12'h010, 1'b0};
    vecs[6] = {1'b0, 8'h00, 12'h000, 1'b0};
    for (int i = 0; i < 7; i++) convert(vecs[i].s, vecs[i].d, vecs[i].bcd, vecs[i].neg, $sformatf("vec%0d", i));
    signed_i = 0;
    data_i = 8'd42;
    q.push_back({12'h042, 1'b0});
    tick();
    chk("mid_busy_rise", busy_o, 1);
    tick();
    tick();
    data_i = 8'd17;
    q.push_back({12'h017, 1'b0});
    run_to_done("mid42", 3);
    tick();
    chk("mid_gap_one_cycle", busy_o, 1);
    run_to_done("mid17", 1);
    convert(1'b0, 8'd123, 12'h123, 1'b0, "u123");
    check_scan("scan123", 8'h4F, 8'h5B, 8'h06, 8'h00);
    convert(1'b0, 8'd7, 12'h007, 1'b0, "u7");
    check_scan("scan7", 8'h07, ZB, ZB, 8'h00);
    convert(1'b1, 8'h80, 12'h128, 1'b1, "s128");
    check_scan("scanneg", 8'h7F, 8'h5B, 8'h06, 8'h40);
    data_i = 8'd200;
    signed_i = 0;
    tick();
    tick();
    tick();
    rst_n = 0;
    data_i = 8'd0;
    tick();
    chk("midrst_busy", busy_o, 0);
    chk("midrst_bcd", bcd_o, 0);
    chk("midrst_neg", neg_o, 0);
    chk("midrst_dig", dig_o, 0);
    chk("midrst_seg", seg_o, 0);
    rst_n = 1;
    tick();
    chk("midrst_rel_dig", dig_o, 4'b0001);
    chk("midrst_rel_seg", seg_o, 8'h3F);
    repeat (12) tick();
    chk("midrst_no_conv", busy_o, 0);
    chk("midrst_bcd_hold", bcd_o, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/display_driver.md
# display_driver

Sequential decoder for the CPU output register. Samples the 8-bit value the output register drives and converts it to BCD with a one-bit-per-cycle shift-and-add-3 engine. Scans the result onto a 4-digit multiplexed 7-segment display. Sits downstream of the output register, on the consumer side of its `display_data` port, and runs on the free-running board clock rather than the halt-gated CPU clock, so the display keeps refreshing after `hlt`.

## Interface
- `SCAN_DIV`, default 1024: clock cycles each digit stays selected; legal range ≥ 2.
- `clk`  input  1  board clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `data_i`  input  8  value from the output register.
- `signed_i`  input  1  1 = interpret `data_i` as two's complement.
- `busy_o`  output  1  conversion in progress.
- `bcd_o`  output  12  last completed result, {hundreds, tens, ones}, 4 bits each.
- `neg_o`  output  1  last completed result is negative.
- `seg_o`  output  8  segments {dp,g,f,e,d,c,b,a}, active-high.
- `dig_o`  output  4  digit select, one-hot, active-high; bit 0 = ones.

## Operation
- Shadow register holds {`signed_i`, `data_i`} of the last accepted request. It resets to {0, 8'h00}.
- **IDLE**:
  - If {`signed_i`, `data_i`} ≠ shadow, latch both into the shadow.
  - Compute the magnitude: `-data_i` when `signed_i` and `data_i[7]` are both set; `data_i` otherwise. 8'h80 signed → magnitude 128.
  - Load the magnitude into the shift register, clear the BCD scratch, set the iteration counter to 0, and go to CONV.
- **CONV**:
  - Each cycle, add 3 to every scratch BCD nibble ≥ 5, then shift {scratch, shift register} left by 1.
  - After iteration 7, go to DONE.
- **DONE**: copy the scratch value to `bcd_o` and the latched sign to `neg_o` in one cycle, then return to IDLE.
- `bcd_o` and `neg_o` change only in DONE. The display never shows partial results.
- Input changes during CONV or DONE do not abort the conversion. IDLE compares against the shadow again, so the newest value is converted next. Intermediate values may be skipped.
- **Scan**:
  - A prescaler counts 0 to `SCAN_DIV`-1; at wrap, `dig_o` rotates left (1000 → 0001).
  - Digits 0, 1 and 2 show ones, tens and hundreds.
  - Digit 3 shows minus (0x40) when `neg_o` = 1, blank (0x00) otherwise.
- Segment encoding, digits 0–9: 3F 06 5B 4F 66 6D 7D 07 7F 6F. `dp` is always 0.
- Ranges: unsigned 0–255; signed -128 to 127.

## Timing
- **Reset**, while `rst_n` = 0 at an edge:
  - State IDLE, shadow {0, 00}, prescaler 0.
  - `busy_o`=0, `bcd_o`=12'h000, `neg_o`=0, `seg_o`=8'h00, `dig_o`=4'b0000.
- **After reset**:
  - At the first edge with `rst_n`=1, `dig_o` becomes 4'b0001 and `seg_o` becomes 8'h3F.
  - `seg_o` is registered: it matches `dig_o` and `bcd_o` from the same edge.
- **Reset mid-conversion** discards all progress and returns every output to its reset value.
- **Latency**:
  - Edge E0 detects the change in IDLE; `busy_o` rises at E0.
  - The 8 CONV cycles run from E1 to E8.
  - DONE at E9 updates `bcd_o` and `neg_o` and drops `busy_o`.
  - Total: 10 cycles from the edge where the input is first seen changed.
- **`busy_o`** is 1 in CONV and DONE (9 cycles).
- **Simultaneous events**: a prescaler wrap on the same edge as a DONE update shows the new digit with the new result.

## Configuration
- **`DISP_BLANK_EN`** defined: leading-zero blanking.
  - Hundreds digit is blank when it is 0.
  - Tens digit is blank when hundreds and tens are both 0.
  - Ones digit is never blanked.
  - Minus stays in digit 3 and is not moved next to the number.
- **Undefined**: all three numeric digits always show, zeros included (e.g. "007").

## Test plan
- **Reset**: assert `rst_n`=0 mid-CONV with `data_i`=200 → next edge gives `busy_o`=0, `bcd_o`=000, `dig_o`=0000. Release → `dig_o`=0001, `seg_o`=3F; no conversion starts while `data_i`=0.
- **Unsigned**: `data_i`=255, `signed_i`=0 → `busy_o` high 9 cycles; 10 cycles after the change, `bcd_o`=12'h255 and `neg_o`=0.
- **Signed**:
  - `data_i`=8'h80, `signed_i`=1 → `bcd_o`=12'h128, `neg_o`=1, digit 3 shows 0x40.
  - `data_i`=8'h7F → `bcd_o`=12'h127, `neg_o`=0.
  - Toggling only `signed_i` with `data_i`=8'hFF retriggers: 255 → -1.
- **Mid-conversion change**: `data_i`=42, then 17 at the 3rd CONV cycle → `bcd_o`=042 at E9, then `bcd_o`=017 10 cycles after the next IDLE; `busy_o` low exactly 1 cycle between the two conversions.
- **Scan**: `SCAN_DIV`=4, `bcd_o`=123 → `dig_o` is 0001, 0010, 0100, 1000, 0001, each for 4 cycles, with `seg_o` 4F, 5B, 06, 00.
- **Blanking**: `data_i`=7 → with `DISP_BLANK_EN`, digits 1 and 2 show 00 and digit 0 shows 07; without it, digits 1 and 2 show 3F.
